// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing helpers and reset constants for the FWFT FIFO controller.
// Status-flag outputs are built only when FIFO_CTRL_STATUS_FLAGS_EN is defined.
package fifo_ctrl_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so the occupancy can represent a completely full FIFO.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam logic RST_RD_VALID = 1'b0;
  localparam logic RST_OVERFLOW = 1'b0;

endpackage

// File: rtl/fifo_dp_ram_ctrl_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module simple_dual_port_RAM #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
    data_out <= mem[read_addr];
  end

endmodule

// File: rtl/fifo_dp_ram_ctrl.sv
// First-word-fall-through FIFO controller wrapped around simple_dual_port_RAM.
// Define FIFO_CTRL_STATUS_FLAGS_EN to add almost_full, almost_empty and overflow.
module fifo_dp_ram_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
`ifdef FIFO_CTRL_STATUS_FLAGS_EN
  ,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [count_width(ADDR_WIDTH)-1:0] count,
  output logic                               full,
  output logic                               empty
`ifdef FIFO_CTRL_STATUS_FLAGS_EN
  ,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               overflow
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  push, pop, write_enable;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid_q && rd_ready;

  assign write_enable = push && !rst;

  // Look one entry ahead on a pop so the next head is registered out in time.
  assign read_addr = pop ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;

  // count_q lags the RAM write by one cycle, so it equals the words written in
  // earlier cycles minus pops: exactly the words the RAM can already return.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_valid_d = ((count_q - CW'(pop)) != '0);
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= RST_RD_VALID;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  simple_dual_port_RAM #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk         (clk),
    .write_enable(write_enable),
    .write_addr  (wr_ptr_q),
    .write_data  (wr_data),
    .read_addr   (read_addr),
    .data_out    (ram_dout)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_dout : '0;
  assign count    = count_q;

`ifdef FIFO_CTRL_STATUS_FLAGS_EN
  logic overflow_q;

  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= RST_OVERFLOW;
    end else if (wr_valid && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_fifo_dp_ram_ctrl.sv
// Randomized self-checking bench for fifo_dp_ram_ctrl against a queue-based model.
// Status-flag checks are included when FIFO_CTRL_STATUS_FLAGS_EN is defined.
module tb_fifo_dp_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
`ifdef FIFO_CTRL_STATUS_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
`endif

  fifo_dp_ram_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data (wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
`ifdef FIFO_CTRL_STATUS_FLAGS_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Model: each stored word remembers the cycle it was accepted in.
  typedef struct {
    logic [DW-1:0] data;
    int            wcyc;
  } entry_t;

  entry_t q[$];
  int     cyc      = 0;
  logic   expValid = 1'b0;
  logic   expOvf   = 1'b0;
  int     total    = 0;
  int     bad      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic checkAll();
    int n;
    n = q.size();
    checkOutput("rd_valid", 32'(rd_valid), 32'(expValid));
    checkOutput("rd_data", 32'(rd_data), (expValid && n > 0) ? 32'(q[0].data) : 32'd0);
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
`ifdef FIFO_CTRL_STATUS_FLAGS_EN
    checkOutput("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= 2));
    checkOutput("overflow", 32'(overflow), 32'(expOvf));
`endif
  endtask

  // One clock cycle: drive, check, then advance the model across the edge.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic doPush, doPop;
    int   vis;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    checkAll();
    doPush = wv && (q.size() < DEPTH);
    doPop  = expValid && rr;
    if (wv && q.size() == DEPTH) expOvf = 1'b1;
    if (doPop) void'(q.pop_front());
    if (doPush) q.push_back('{data: wd, wcyc: cyc});
    vis = 0;
    foreach (q[i]) if (q[i].wcyc < cyc) vis++;
    expValid = (vis > 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic doReset(input int n);
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    rd_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    q.delete();
    expValid = 1'b0;
    expOvf   = 1'b0;
    checkAll();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Reset, then single-word latency
    doReset(2);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

    // Fill to full, attempt an extra write, drain
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    repeat (2) applyStimulus(1'b1, 8'hFF, 1'b0);
    repeat (DEPTH + 3) applyStimulus(1'b0, 8'h00, 1'b1);

    // Continuous streaming across pointer wrap
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1);

    // Full with simultaneous pop, then a push the next cycle
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b0);
    applyStimulus(1'b1, 8'hFD, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Mid-operation reset with queued words
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b0);
    doReset(1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b1);

    // Random traffic with varying producer/consumer bias
    for (int phase = 0; phase < 4; phase++) begin
      int wBias, rBias;
      wBias = (phase == 1) ? 90 : (phase == 2) ? 30 : 60;
      rBias = (phase == 1) ? 30 : (phase == 2) ? 90 : 60;
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(99) < wBias, 8'($urandom_range(255)),
                      $urandom_range(99) < rBias);
      end
    end
    repeat (DEPTH + 3) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
